// File: rtl/fetch_queue.sv
// fetch_queue: IF->ID prefetch FIFO with flush; FETCH_QUEUE_BYPASS_EN enables empty-queue bypass
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [31:0]   inst_in,
   input  logic [31:0]   pc4_in,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          id_write,
   input  logic          flush,
   output logic [31:0]   inst_out,
   output logic [31:0]   pc4_out,
   output logic          out_valid,
   output logic [AW:0]   count
);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          empty, byp, push, pop, wr, rd;
   assign empty = count == '0;
`ifdef FETCH_QUEUE_BYPASS_EN
   assign byp = empty & in_valid & ~flush;
`else
   assign byp = 1'b0;
`endif
   assign out_valid = ~empty | byp;
   assign inst_out  = byp ? inst_in : (out_valid ? mem[rd_ptr][63:32] : 32'd0);
   assign pc4_out   = byp ? pc4_in  : (out_valid ? mem[rd_ptr][31:0]  : 32'd0);
   assign in_ready  = (count != FULL) | (out_valid & id_write);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & id_write & ~flush;
   // a bypassed entry consumed in the same cycle never touches storage
   assign wr        = push & ~(byp & id_write);
   assign rd        = pop & ~empty;
   always_ff @(posedge clk)
      if (wr) mem[wr_ptr] <= {inst_in, pc4_in};
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + 1'b1;
         if (rd) rd_ptr <= rd_ptr + 1'b1;
         count <= (wr & ~rd) ? count + 1'b1 : (rd & ~wr) ? count - 1'b1 : count;
      end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue
module tb_fetch_queue;
   logic        clk = 0, rst = 1;
   logic [31:0] inst_in = 0, pc4_in = 0, inst_out, pc4_out;
   logic        in_valid = 0, in_ready, id_write = 0, flush = 0, out_valid;
   logic [2:0]  count;
   int vecs = 0, errs = 0;

   fetch_queue #(.DEPTH(4), .AW(2)) dut (
      .clk(clk), .rst(rst), .inst_in(inst_in), .pc4_in(pc4_in), .in_valid(in_valid),
      .in_ready(in_ready), .id_write(id_write), .flush(flush), .inst_out(inst_out),
      .pc4_out(pc4_out), .out_valid(out_valid), .count(count));

   always #5 clk = ~clk;

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic push1(input logic [31:0] i, input logic [31:0] p);
      in_valid = 1; inst_in = i; pc4_in = p; id_write = 0;
      cyc();
      in_valid = 0;
   endtask

   task automatic test_reset;
      cyc(); cyc();
      vecs++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL reset_init count=%0d ov=%b rdy=%b want 0/0/1", count, out_valid, in_ready); end
      rst = 0;
      push1(32'h1, 32'h4); push1(32'h2, 32'h8); push1(32'h3, 32'hc);
      vecs++; if (count !== 3'd3) begin errs++; $display("FAIL reset_pre count=%0d want 3", count); end
      #2 rst = 1;
      #1;
      vecs++; if (count !== 3'd0 || out_valid !== 1'b0 || inst_out !== 32'd0 || in_ready !== 1'b1) begin errs++; $display("FAIL reset_async count=%0d ov=%b inst=%h rdy=%b want 0/0/0/1", count, out_valid, inst_out, in_ready); end
      cyc();
      rst = 0;
      cyc();
   endtask

   task automatic test_fill;
      push1(32'h20080005, 32'd4); push1(32'h20090007, 32'd8);
      push1(32'h01095020, 32'd12); push1(32'hAC0A0000, 32'd16);
      vecs++; if (count !== 3'd4 || in_ready !== 1'b0) begin errs++; $display("FAIL fill_full count=%0d rdy=%b want 4/0", count, in_ready); end
      vecs++; if (inst_out !== 32'h20080005 || pc4_out !== 32'd4 || out_valid !== 1'b1) begin errs++; $display("FAIL fill_head inst=%h pc4=%0d want 20080005/4", inst_out, pc4_out); end
   endtask

   task automatic test_full_push_pop;
      logic [31:0] exp [4];
      exp[0] = 32'h20090007; exp[1] = 32'h01095020; exp[2] = 32'hAC0A0000; exp[3] = 32'h08000010;
      in_valid = 1; inst_in = 32'h08000010; pc4_in = 32'd20; id_write = 1;
      #1;
      vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL fpp_ready rdy=%b want 1", in_ready); end
      cyc();
      in_valid = 0;
      vecs++; if (count !== 3'd4 || inst_out !== 32'h20090007) begin errs++; $display("FAIL fpp_adv count=%0d inst=%h want 4/20090007", count, inst_out); end
      for (int i = 0; i < 4; i++) begin
         vecs++; if (inst_out !== exp[i] || out_valid !== 1'b1) begin errs++; $display("FAIL drain_%0d inst=%h want %h", i, inst_out, exp[i]); end
         cyc();
      end
      id_write = 0;
      vecs++; if (count !== 3'd0 || out_valid !== 1'b0 || inst_out !== 32'd0) begin errs++; $display("FAIL drain_empty count=%0d ov=%b inst=%h want 0/0/0", count, out_valid, inst_out); end
   endtask

   task automatic test_wrap;
      for (int i = 0; i < 10; i++) begin
         push1(32'hA000_0000 + 32'(i), 32'(4 * i + 4));
         vecs++; if (inst_out !== 32'hA000_0000 + 32'(i) || pc4_out !== 32'(4 * i + 4) || count !== 3'd1) begin errs++; $display("FAIL wrap_%0d inst=%h pc4=%0d count=%0d want %h/%0d/1", i, inst_out, pc4_out, count, 32'hA000_0000 + 32'(i), 4 * i + 4); end
         id_write = 1;
         cyc();
         id_write = 0;
      end
      vecs++; if (count !== 3'd0 || out_valid !== 1'b0) begin errs++; $display("FAIL wrap_end count=%0d ov=%b want 0/0", count, out_valid); end
   endtask

   task automatic test_flush;
      push1(32'h11, 32'h4); push1(32'h22, 32'h8); push1(32'h33, 32'hc);
      in_valid = 1; inst_in = 32'hDEADBEEF; pc4_in = 32'h10; flush = 1; id_write = 1;
      cyc();
      in_valid = 0; flush = 0; id_write = 0;
      vecs++; if (count !== 3'd0 || out_valid !== 1'b0 || inst_out !== 32'd0) begin errs++; $display("FAIL flush count=%0d ov=%b inst=%h want 0/0/0", count, out_valid, inst_out); end
      push1(32'h55, 32'h40);
      vecs++; if (inst_out !== 32'h55 || count !== 3'd1) begin errs++; $display("FAIL flush_after inst=%h count=%0d want 55/1", inst_out, count); end
      id_write = 1;
      cyc();
      id_write = 0;
      vecs++; if (count !== 3'd0) begin errs++; $display("FAIL flush_drain count=%0d want 0", count); end
   endtask

   task automatic test_bypass;
      in_valid = 1; inst_in = 32'h8C0B0004; pc4_in = 32'h24; id_write = 1;
      #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      vecs++; if (out_valid !== 1'b1 || inst_out !== 32'h8C0B0004 || pc4_out !== 32'h24) begin errs++; $display("FAIL byp_same ov=%b inst=%h want 1/8c0b0004", out_valid, inst_out); end
`else
      vecs++; if (out_valid !== 1'b0 || inst_out !== 32'd0) begin errs++; $display("FAIL byp_same ov=%b inst=%h want 0/0", out_valid, inst_out); end
`endif
      cyc();
      in_valid = 0;
      #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      vecs++; if (count !== 3'd0 || out_valid !== 1'b0) begin errs++; $display("FAIL byp_next count=%0d ov=%b want 0/0", count, out_valid); end
`else
      vecs++; if (count !== 3'd1 || out_valid !== 1'b1 || inst_out !== 32'h8C0B0004) begin errs++; $display("FAIL byp_next count=%0d ov=%b inst=%h want 1/1/8c0b0004", count, out_valid, inst_out); end
`endif
      cyc();
      id_write = 0;
      vecs++; if (count !== 3'd0) begin errs++; $display("FAIL byp_end count=%0d want 0", count); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_full_push_pop();
      test_wrap();
      test_flush();
      test_bypass();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
